// File: rtl/des_hash_pkg.sv
// des_hash_pkg: shared types and constants for the streaming DES-S-box hash engine.
// Contents: FSM state enum, default initial hash value, the eight DES S-box
// tables and an S-box lookup helper.
package des_hash_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Initial hash value; upper bits are zero when a wider digest is configured.
    localparam logic [63:0] DEFAULT_IV = 64'h0000_0000_6745_2301;

    // Element k = row*16 + col; element 0 is the leftmost hex digit.
    localparam logic [0:63][3:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_74B19CE206ADF358_21E74A8DFC90356B
    };

    // DES S-box number num (1..8); row = {idx[5], idx[0]}, col = idx[4:1].
    function automatic logic [3:0] sbox(input int unsigned num, input logic [5:0] idx);
        logic [5:0] k;
        k = {idx[5], idx[0], idx[4:1]};
        return SBOX[3'(num - 1)][k];
    endfunction

endpackage

// File: rtl/des_hash_byte_round.sv
// des_hash_byte_round: absorbs one message byte into the hash state (combinational).
// Ports:
//   h_i  [DIGEST_W]  current hash state, nibble 0 in bits 3:0
//   m_i  [8]         message byte
//   h_o  [DIGEST_W]  updated hash state
module des_hash_byte_round
    import des_hash_pkg::*;
#(
    parameter int unsigned DIGEST_W = 32
) (
    input  logic [DIGEST_W-1:0] h_i,
    input  logic [7:0]          m_i,
    output logic [DIGEST_W-1:0] h_o
);

    localparam int unsigned N = DIGEST_W / 4;

    logic [DIGEST_W-1:0] h_mix;

    // Each nibble picks two message bits, looks up its S-box and mixes in the next nibble.
    for (genvar i = 0; i < N; i++) begin : g_nib
        logic [5:0] idx;
        assign idx = {m_i[(2*i+1)%8], m_i[(2*i)%8], h_i[4*i +: 4]};
        assign h_mix[4*i +: 4] = h_i[4*((i+1)%N) +: 4] ^ sbox((i % 8) + 1, idx);
    end

    assign h_o = {h_mix[DIGEST_W-3:0], h_mix[DIGEST_W-1 -: 2]};

endmodule

// File: rtl/des_hash_stream.sv
// des_hash_stream: streaming DES-S-box hash over a length-announced message.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start_valid/start_ready/len_in message request with byte length (ready only in IDLE)
//   data_valid/data_ready/data_in  BYTES_PER_BEAT bytes per beat, lane 0 earliest
//   digest_valid/digest_ready/digest_out  final hash, held until consumed
module des_hash_stream
    import des_hash_pkg::*;
#(
    parameter int unsigned DIGEST_W       = 32,
    parameter int unsigned BYTES_PER_BEAT = 1,
    parameter logic [63:0] IV             = DEFAULT_IV
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [63:0]                 len_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic [8*BYTES_PER_BEAT-1:0] data_in,
    output logic                        digest_valid,
    input  logic                        digest_ready,
    output logic [DIGEST_W-1:0]         digest_out
);

    localparam int unsigned BPB       = BYTES_PER_BEAT;
    localparam int unsigned FIN_BEATS = 8 / BPB;
    localparam logic [DIGEST_W-1:0] IV_W = IV[DIGEST_W-1:0];

    state_e              state_q, state_d;
    logic [DIGEST_W-1:0] h_q, h_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [63:0]         rem_q, rem_d;
    logic [63:0]         len_q, len_d;
    logic [3:0]          fin_q, fin_d;
    logic                start_ready_q, start_ready_d;
    logic                data_ready_q, data_ready_d;
    logic                digest_valid_q, digest_valid_d;
    logic [63:0]         beat_n;
    logic [DIGEST_W-1:0] h_last;

    // Lane chain: in FINAL the lanes carry the (shifted) length, otherwise data_in;
    // a lane beyond the remaining byte count passes the state through untouched.
    for (genvar l = 0; l < BPB; l++) begin : g_lane
        logic [DIGEST_W-1:0] h_in;
        logic [DIGEST_W-1:0] h_rnd;
        logic [DIGEST_W-1:0] h_out;
        logic [7:0]          lane_byte;
        logic                lane_en;

        if (l == 0) begin : g_first
            assign h_in = h_q;
        end else begin : g_next
            assign h_in = g_lane[l-1].h_out;
        end

        assign lane_byte = (state_q == S_FINAL) ? len_q[8*l +: 8] : data_in[8*l +: 8];
        assign lane_en   = (state_q == S_FINAL) || (64'(l) < rem_q);

        des_hash_byte_round #(.DIGEST_W(DIGEST_W)) u_round (
            .h_i (h_in),
            .m_i (lane_byte),
            .h_o (h_rnd)
        );

        assign h_out = lane_en ? h_rnd : h_in;
    end

    assign h_last = g_lane[BPB-1].h_out;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            h_q            <= IV_W;
            digest_q       <= '0;
            rem_q          <= '0;
            len_q          <= '0;
            fin_q          <= '0;
            start_ready_q  <= 1'b1;
            data_ready_q   <= 1'b0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_q            <= h_d;
            digest_q       <= digest_d;
            rem_q          <= rem_d;
            len_q          <= len_d;
            fin_q          <= fin_d;
            start_ready_q  <= start_ready_d;
            data_ready_q   <= data_ready_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    // Next-state logic; handshake flags are registered from the next state.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        digest_d = digest_q;
        rem_d    = rem_q;
        len_d    = len_q;
        fin_d    = fin_q;
        beat_n   = (rem_q < 64'(BPB)) ? rem_q : 64'(BPB);

        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    h_d     = IV_W;
                    rem_d   = len_in;
                    len_d   = len_in;
                    fin_d   = '0;
                    state_d = (len_in != '0) ? S_DATA : S_FINAL;
                end
            end
            S_DATA: begin
                if (data_valid) begin
                    h_d   = h_last;
                    rem_d = rem_q - beat_n;
                    if (rem_q <= 64'(BPB)) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                // Length bytes go out little-endian, BPB per cycle.
                h_d   = h_last;
                len_d = len_q >> (8 * BPB);
                fin_d = fin_q + 4'd1;
                if (fin_q == 4'(FIN_BEATS - 1)) begin
                    state_d  = S_DONE;
                    digest_d = h_last;
                end
            end
            S_DONE: begin
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        start_ready_d  = (state_d == S_IDLE);
        data_ready_d   = (state_d == S_DATA);
        digest_valid_d = (state_d == S_DONE);
    end

    assign start_ready  = start_ready_q;
    assign data_ready   = data_ready_q;
    assign digest_valid = digest_valid_q;
    assign digest_out   = digest_q;

endmodule

// File: tb/tb_des_hash_stream.sv
// tb_des_hash_stream: directed bench for des_hash_stream (32-bit digest), one
// instance with 1 byte lane and one with 4 byte lanes, checked against an
// independent byte-round model.
module tb_des_hash_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid, start_ready, data_valid, data_ready, digest_valid, digest_ready;
    logic [63:0] len_in;
    logic [7:0]  data_in;
    logic [31:0] digest_out;

    logic        s4_valid, s4_ready, dv4, dr4_out, dg4_valid, dg4_ready;
    logic [63:0] len4;
    logic [31:0] din4, digest4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    des_hash_stream #(.DIGEST_W(32), .BYTES_PER_BEAT(1)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .len_in(len_in),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .digest_valid(digest_valid), .digest_ready(digest_ready), .digest_out(digest_out)
    );

    des_hash_stream #(.DIGEST_W(32), .BYTES_PER_BEAT(4)) dut4 (
        .clk(clk), .rst(rst),
        .start_valid(s4_valid), .start_ready(s4_ready), .len_in(len4),
        .data_valid(dv4), .data_ready(dr4_out), .data_in(din4),
        .digest_valid(dg4_valid), .digest_ready(dg4_ready), .digest_out(digest4)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] sb_row(input int k);
        case (k)
            0:  return 64'hE4D12FB83A6C5907;  1: return 64'h0F74E2D1A6CB9538;
            2:  return 64'h41E8D62BFC973A50;  3: return 64'hFC8249175B3EA06D;
            4:  return 64'hF18E6B34972DC05A;  5: return 64'h3D47F28EC01A69B5;
            6:  return 64'h0E7BA4D158C6932F;  7: return 64'hD8A13F42B67C05E9;
            8:  return 64'hA09E63F51DC7B428;  9: return 64'hD709346A285ECBF1;
            10: return 64'hD6498F30B12C5AE7; 11: return 64'h1AD069874FE3B52C;
            12: return 64'h7DE3069A1285BC4F; 13: return 64'hD8B56F03472C1AE9;
            14: return 64'hA690CB7DF13E5284; 15: return 64'h3F06A1D8945BC72E;
            16: return 64'h2C417AB6853FD0E9; 17: return 64'hEB2C47D150FA3986;
            18: return 64'h421BAD78F9C5630E; 19: return 64'hB8C71E2D6F09A453;
            20: return 64'hC1AF92680D34E75B; 21: return 64'hAF427C9561DE0B38;
            22: return 64'h9EF528C3704A1DB6; 23: return 64'h432C95FABE17608D;
            24: return 64'h4B2EF08D3C975A61; 25: return 64'hD0B7491AE35C2F86;
            26: return 64'h14BDC37EAF680592; 27: return 64'h6BD814A7950FE23C;
            28: return 64'hD2846FB1A93E50C7; 29: return 64'h1FD8A374C56B0E92;
            30: return 64'h74B19CE206ADF358; default: return 64'h21E74A8DFC90356B;
        endcase
    endfunction

    function automatic logic [31:0] model_round(input logic [31:0] h, input logic [7:0] m);
        logic [31:0] t;
        logic [63:0] r;
        int row, col;
        for (int i = 0; i < 8; i++) begin
            row = {30'd0, m[(2*i+1)%8], h[4*i]};
            col = {28'd0, m[(2*i)%8], h[4*i+3], h[4*i+2], h[4*i+1]};
            r = sb_row(i*4 + row);
            t[4*i +: 4] = h[4*((i+1)%8) +: 4] ^ r[63-4*col -: 4];
        end
        return {t[29:0], t[31:30]};
    endfunction

    // pat 0: byte j = j mod 256, pat 1: every byte 8'h41
    function automatic logic [31:0] model(input longint unsigned len, input int pat);
        logic [31:0] h;
        h = 32'h67452301;
        for (longint unsigned j = 0; j < len; j++)
            h = model_round(h, (pat != 0) ? 8'h41 : 8'(j));
        for (int k = 0; k < 8; k++)
            h = model_round(h, 8'(len >> (8*k)));
        return h;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input longint unsigned len);
        int t;
        t = 0;
        while (!start_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("start_wait", 64'(t < 50), 64'd1);
        start_valid = 1'b1;
        len_in      = len;
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic do_data(input longint unsigned n_send, input int pat, input int gap,
                           output int hs);
        int   cyc, gap_cnt;
        logic fire;
        hs = 0; cyc = 0; gap_cnt = 0;
        while (longint'(hs) < longint'(n_send) && cyc < 5000) begin
            if (gap_cnt > 0) begin
                data_valid = 1'b0;
                gap_cnt--;
            end else begin
                data_valid = 1'b1;
                data_in    = (pat != 0) ? 8'h41 : 8'(hs);
            end
            fire = data_valid && data_ready;
            @(negedge clk);
            cyc++;
            if (fire) begin
                hs++;
                gap_cnt = gap;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic wait_digest(output int lat);
        lat = 0;
        while (!digest_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_digest(output logic [31:0] d);
        d = digest_out;
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
    endtask

    task automatic run4(input bit garbage, output logic [31:0] d, output int hs, output int lat);
        int   sent, cyc, t;
        logic fire;
        t = 0;
        while (!s4_ready && t < 50) begin @(negedge clk); t++; end
        s4_valid = 1'b1;
        len4     = 64'd5073;
        @(negedge clk);
        s4_valid = 1'b0;
        sent = 0; hs = 0; cyc = 0;
        while (sent < 5073 && cyc < 3000) begin
            dv4 = 1'b1;
            for (int l = 0; l < 4; l++)
                din4[8*l +: 8] = (sent + l < 5073) ? 8'(sent + l) : (garbage ? 8'($urandom) : 8'h00);
            fire = dv4 && dr4_out;
            @(negedge clk);
            cyc++;
            if (fire) begin hs++; sent += 4; end
        end
        dv4 = 1'b0;
        lat = 0;
        while (!dg4_valid && lat < 100) begin @(negedge clk); lat++; end
        d = digest4;
        dg4_ready = 1'b1;
        @(negedge clk);
        dg4_ready = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        longint unsigned len;
        int              pat;
        int              gap;
        logic [31:0]     exp;
    } vec_t;

    vec_t        vec [6];
    logic [31:0] got [6];
    logic [31:0] d, d2;
    int          hs, lat;

    initial begin
        rst = 1'b1; start_valid = 0; len_in = 0; data_valid = 0; data_in = 0; digest_ready = 0;
        s4_valid = 0; len4 = 0; dv4 = 0; din4 = 0; dg4_ready = 0;

        vec[0] = '{len: 0,   pat: 0, gap: 0, exp: 32'h0};
        vec[1] = '{len: 1,   pat: 1, gap: 0, exp: 32'h0};
        vec[2] = '{len: 156, pat: 0, gap: 0, exp: 32'h0};
        vec[3] = '{len: 156, pat: 0, gap: 2, exp: 32'h0};
        vec[4] = '{len: 255, pat: 0, gap: 0, exp: 32'h0};
        vec[5] = '{len: 7,   pat: 0, gap: 1, exp: 32'h0};
        for (int i = 0; i < 6; i++) vec[i].exp = model(vec[i].len, vec[i].pat);

        repeat (2) @(negedge clk);
        chk("rst_start_ready", 64'(start_ready), 64'd1);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_digest_valid", 64'(digest_valid), 64'd0);
        chk("rst_digest_out", 64'(digest_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // table: digest, latency and handshake count per message
        for (int i = 0; i < 6; i++) begin
            do_start(vec[i].len);
            chk($sformatf("start_ready_drop[%0d]", i), 64'(start_ready), 64'd0);
            do_data(vec[i].len, vec[i].pat, vec[i].gap, hs);
            chk($sformatf("hs_count[%0d]", i), 64'(hs), vec[i].len);
            chk($sformatf("data_ready_off[%0d]", i), 64'(data_ready), 64'd0);
            wait_digest(lat);
            chk($sformatf("latency[%0d]", i), 64'(lat), 64'd8);
            chk($sformatf("digest[%0d]", i), 64'(digest_out), 64'(vec[i].exp));
            take_digest(got[i]);
            chk($sformatf("valid_drop[%0d]", i), 64'(digest_valid), 64'd0);
        end
        chk("gap_invariant", 64'(got[3]), 64'(got[2]));
        chk("len255_differs", 64'(got[4] != got[2]), 64'd1);

        // digest held under backpressure, start ignored until the digest is taken
        do_start(1);
        do_data(1, 1, 0, hs);
        wait_digest(lat);
        start_valid = 1'b1;
        len_in      = 64'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("hold_valid[%0d]", c), 64'(digest_valid), 64'd1);
            chk($sformatf("hold_digest[%0d]", c), 64'(digest_out), 64'(vec[1].exp));
            chk($sformatf("hold_start_ready[%0d]", c), 64'(start_ready), 64'd0);
        end
        take_digest(d);
        chk("bp_valid_drop", 64'(digest_valid), 64'd0);
        chk("bp_start_ready", 64'(start_ready), 64'd1);
        chk("bp_digest_hold", 64'(digest_out), 64'(vec[1].exp));
        @(negedge clk);
        start_valid = 1'b0;
        chk("bp_start_taken", 64'(start_ready), 64'd0);
        wait_digest(lat);
        chk("bp_next_latency", 64'(lat), 64'd8);
        chk("bp_next_digest", 64'(digest_out), 64'(vec[0].exp));
        take_digest(d);

        // reset in the middle of a message
        do_start(156);
        do_data(50, 0, 0, hs);
        rst        = 1'b1;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk("mid_rst_start_ready", 64'(start_ready), 64'd1);
        chk("mid_rst_data_ready", 64'(data_ready), 64'd0);
        chk("mid_rst_digest_valid", 64'(digest_valid), 64'd0);
        chk("mid_rst_digest_out", 64'(digest_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        do_start(1);
        do_data(1, 1, 0, hs);
        wait_digest(lat);
        chk("after_rst_latency", 64'(lat), 64'd8);
        take_digest(d);
        chk("after_rst_digest", 64'(d), 64'(got[1]));

        // four lanes per beat, partial last beat
        run4(1'b0, d, hs, lat);
        chk("bpb4_hs", 64'(hs), 64'd1269);
        chk("bpb4_final_cycles", 64'(lat), 64'd2);
        chk("bpb4_digest", 64'(d), 64'(model(5073, 0)));
        run4(1'b1, d2, hs, lat);
        chk("bpb4_garbage_digest", 64'(d2), 64'(model(5073, 0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
